// File: rtl/vending_pkg.sv
// Shared coin encoding, FSM states and greedy-change helpers for the vending controller.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  typedef enum logic [1:0] {ACCEPT, VEND, CHANGE} state_t;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_5:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] largest_coin(input logic [31:0] amount);
    if (amount >= 32'd5)      return COIN_5;
    else if (amount >= 32'd2) return COIN_2;
    else if (amount >= 32'd1) return COIN_1;
    else                      return COIN_NONE;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Pays out an amount one greedy coin per cycle; an echo code (rejected coin) takes the
// output slot for one cycle without reducing the amount still owed.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_amount,
  input  logic [1:0]          i_echo,
  output logic [1:0]          o_cambio,
  output logic [CREDIT_W-1:0] o_rem,
  output logic                o_done
);

  logic [1:0]          r_cambio;
  logic [CREDIT_W-1:0] r_rem;
  logic [CREDIT_W-1:0] w_src;
  logic [1:0]          w_coin;

  assign w_src  = i_load ? i_amount : r_rem;
  assign w_coin = largest_coin(32'(w_src));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cambio <= COIN_NONE;
      r_rem    <= '0;
    end else if (i_echo != COIN_NONE) begin
      r_cambio <= i_echo;
      r_rem    <= w_src;
    end else begin
      // With nothing owed w_coin is COIN_NONE, so this also idles the output.
      r_cambio <= w_coin;
      r_rem    <= w_src - CREDIT_W'(coin_value(w_coin));
    end
  end

  assign o_cambio = r_cambio;
  assign o_rem    = r_rem;
  assign o_done   = (r_rem == '0);

endmodule

// File: rtl/vending_ctrl_param.sv
// Vending controller: coin credit, per-product price/stock, vend pulse, greedy refund.
// Moore outputs; credit shown during CHANGE is the amount the dispenser still owes.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int                        N_PROD     = 4,
  parameter int                        CREDIT_W   = 8,
  parameter int                        STOCK_W    = 4,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES    = {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int                        STOCK_INIT = 5,
  localparam int                       SEL_W      = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          moneda,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    seleccion,
  input  logic                cancelar,
  input  logic                refill,
  output logic [SEL_W-1:0]    producto,
  output logic                listo,
  output logic [1:0]          cambio,
  output logic [CREDIT_W-1:0] credito,
  output logic                agotado,
  output logic                ocupado
);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [STOCK_W-1:0]  r_stock [N_PROD];
  logic [SEL_W-1:0]    r_producto;
  logic                r_listo, r_agotado, r_ocupado;

  logic [CREDIT_W-1:0] w_prices [N_PROD];
  logic [CREDIT_W:0]   w_sum;
  logic                w_ovf, w_accept, w_cancel, w_sel, w_sel_ok, w_vend, w_empty, w_refill;
  logic [CREDIT_W-1:0] w_credit_in, w_price, w_load_amt, w_rem;
  logic [STOCK_W-1:0]  w_stock_sel;
  logic                w_load, w_done;
  logic [1:0]          w_echo;

  for (genvar g = 0; g < N_PROD; g++) begin : g_price
    assign w_prices[g] = PRICES[g*CREDIT_W +: CREDIT_W];
  end

  assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(moneda));
  assign w_ovf       = w_sum[CREDIT_W];
  assign w_credit_in = w_ovf ? r_credit : w_sum[CREDIT_W-1:0];

  assign w_accept    = (r_state == ACCEPT);
  assign w_cancel    = w_accept && cancelar;
  assign w_sel       = w_accept && !cancelar && sel_valid;
  assign w_refill    = w_accept && !cancelar && !sel_valid && refill;
  assign w_sel_ok    = (32'(seleccion) < 32'(N_PROD));
  assign w_price     = w_prices[seleccion];
  assign w_stock_sel = r_stock[seleccion];
  // Affordability uses the credit held before this cycle's coin.
  assign w_empty     = w_sel && w_sel_ok && (w_stock_sel == '0);
  assign w_vend      = w_sel && w_sel_ok && (w_stock_sel != '0) && (r_credit >= w_price);

  assign w_echo      = (w_accept && w_ovf) ? moneda : COIN_NONE;
  assign w_load      = (w_cancel && (w_credit_in != '0)) || ((r_state == VEND) && (r_credit != '0));
  assign w_load_amt  = (r_state == VEND) ? r_credit : w_credit_in;

  change_dispenser #(.CREDIT_W(CREDIT_W)) u_disp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_amount (w_load_amt),
    .i_echo   (w_echo),
    .o_cambio (cambio),
    .o_rem    (w_rem),
    .o_done   (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACCEPT;
      r_credit   <= '0;
      r_producto <= '0;
      r_listo    <= 1'b0;
      r_agotado  <= 1'b0;
      r_ocupado  <= 1'b0;
      for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      r_listo   <= 1'b0;
      r_agotado <= 1'b0;
      case (r_state)
        ACCEPT: begin
          r_credit <= w_credit_in;
          if (w_cancel) begin
            if (w_credit_in != '0) begin
              r_state   <= CHANGE;
              r_ocupado <= 1'b1;
              r_credit  <= '0;
            end
          end else if (w_vend) begin
            r_state             <= VEND;
            r_ocupado           <= 1'b1;
            r_listo             <= 1'b1;
            r_producto          <= seleccion;
            r_credit            <= w_credit_in - w_price;
            r_stock[seleccion]  <= w_stock_sel - STOCK_W'(1);
          end else if (w_empty) begin
            r_agotado <= 1'b1;
          end else if (w_refill) begin
            for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
          end
        end
        VEND: begin
          // Leftover credit is handed to the dispenser, which owns it until paid out.
          if (r_credit != '0) begin
            r_state  <= CHANGE;
            r_credit <= '0;
          end else begin
            r_state   <= ACCEPT;
            r_ocupado <= 1'b0;
          end
        end
        CHANGE: begin
          if (w_done) begin
            r_state   <= ACCEPT;
            r_ocupado <= 1'b0;
          end
        end
        default: begin
          r_state   <= ACCEPT;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign producto = r_producto;
  assign listo    = r_listo;
  assign agotado  = r_agotado;
  assign ocupado  = r_ocupado;
  assign credito  = (r_state == CHANGE) ? w_rem : r_credit;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed scenarios plus random traffic against a transaction-level model of the vending controller.
module tb_vending_ctrl_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel_valid, cancelar, refill;
  logic [1:0] moneda, seleccion;
  logic [1:0] producto, cambio;
  logic       listo, agotado, ocupado;
  logic [7:0] credito;

  vending_ctrl_param dut (
    .clk       (clk),
    .rst       (rst),
    .moneda    (moneda),
    .sel_valid (sel_valid),
    .seleccion (seleccion),
    .cancelar  (cancelar),
    .refill    (refill),
    .producto  (producto),
    .listo     (listo),
    .cambio    (cambio),
    .credito   (credito),
    .agotado   (agotado),
    .ocupado   (ocupado)
  );

  typedef struct {
    int listo; int prod; int cambio; int credito; int agotado; int ocupado;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;
  int   m_credit, m_prod;
  int   m_stock [4];
  bit   m_busy;
  int   price_tab [4] = '{2, 3, 5, 7};
  int   coin_val  [4] = '{0, 1, 2, 5};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic rec_t mk(int li, int ca, int cr, int ag, int oc);
    rec_t r;
    r.listo = li; r.prod = m_prod; r.cambio = ca; r.credito = cr; r.agotado = ag; r.ocupado = oc;
    return r;
  endfunction

  // Greedy refund: one coin per cycle, credit shown is what is still owed after that coin.
  task automatic push_refund(input int amt);
    int rem = amt;
    while (rem > 0) begin
      int c;
      if (rem >= 5) c = 5; else if (rem >= 2) c = 2; else c = 1;
      rem -= c;
      q.push_back(mk(0, (c == 5) ? 3 : c, rem, 0, 1));
    end
  endtask

  task automatic model_edge();
    int v, sum, cin, echo, ag;
    if (rst) begin
      q.delete();
      m_credit = 0; m_prod = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 5;
      exp_r = mk(0, 0, 0, 0, 0);
    end else if (m_busy) begin
      if (q.size() > 0) exp_r = q.pop_front();
      else              exp_r = mk(0, 0, m_credit, 0, 0);
    end else begin
      v    = coin_val[moneda];
      sum  = m_credit + v;
      echo = (sum > 255) ? int'(moneda) : 0;
      cin  = (sum > 255) ? m_credit : sum;
      ag   = 0;
      if (cancelar) begin
        if (cin > 0) begin
          if (echo != 0) q.push_back(mk(0, echo, cin, 0, 1));
          push_refund(cin);
          m_credit = 0;
        end else m_credit = cin;
      end else if (sel_valid) begin
        if (m_stock[seleccion] == 0) begin
          ag = 1; m_credit = cin;
        end else if (m_credit < price_tab[seleccion]) begin
          m_credit = cin;
        end else begin
          m_stock[seleccion]--;
          m_prod = int'(seleccion);
          q.push_back(mk(1, echo, cin - price_tab[seleccion], 0, 1));
          push_refund(cin - price_tab[seleccion]);
          m_credit = 0;
        end
      end else begin
        m_credit = cin;
        if (refill) for (int i = 0; i < 4; i++) m_stock[i] = 5;
      end
      if (q.size() > 0) exp_r = q.pop_front();
      else              exp_r = mk(0, echo, m_credit, ag, 0);
    end
    m_busy = (exp_r.ocupado != 0);
  endtask

  task automatic step(input logic [1:0] mo, input logic sv, input logic [1:0] se,
                      input logic ca, input logic rf, input logic rs);
    moneda = mo; sel_valid = sv; seleccion = se; cancelar = ca; refill = rf; rst = rs;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("listo",    int'(listo),    exp_r.listo);
    chk("producto", int'(producto), exp_r.prod);
    chk("cambio",   int'(cambio),   exp_r.cambio);
    chk("credito",  int'(credito),  exp_r.credito);
    chk("agotado",  int'(agotado),  exp_r.agotado);
    chk("ocupado",  int'(ocupado),  exp_r.ocupado);
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && m_busy; k++) idle(1);
    idle(1);
  endtask

  initial begin
    moneda = 2'b00; sel_valid = 1'b0; seleccion = 2'd0; cancelar = 1'b0; refill = 1'b0; rst = 1'b0;
    @(negedge clk);

    // 1: credit 7, buy product 1, change 2+2
    step(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("t1_listo", int'(listo), 1);
    chk("t1_producto", int'(producto), 1);
    idle(4);

    // 2: credit 2 cannot buy product 3; cancel refunds 2
    step(2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // 3: exhaust product 0, hit sold-out, restock, buy again
    for (int k = 0; k < 6; k++) begin
      step(2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step(2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drain();

    // 4: credit 254 -> 255 -> overflow echo; then refund everything
    repeat (50) step(2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2)  step(2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t4_credito", int'(credito), 255);
    chk("t4_echo", int'(cambio), 2);
    step(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    drain();

    // 5: coin 5 together with cancel on credit 1
    step(2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("t5_first", int'(cambio), 3);
    idle(3);

    // 6: reset while 5 is still owed
    step(2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] mo, se;
      logic       sv, ca, rf, rs;
      mo = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sv = ($urandom_range(0, 4) == 0);
      se = 2'($urandom_range(0, 3));
      ca = ($urandom_range(0, 15) == 0);
      rf = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(mo, sv, se, ca, rf, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vending_ctrl_param.md
# vending_ctrl_param

Parametrised vending-machine controller, successor to the fixed two-product Moore machine behind `top_maquina`. It accumulates coin credit and supports `N_PROD` products with per-product prices and stock counters. It vends on a valid selection, returns change greedily one coin per cycle, and supports cancel/refund and restock. It sits directly under the board top, which drives coins and selections from switches/buttons and shows outputs on LEDs.

## Interface
Parameters:
- `N_PROD`, 4: number of products; `SEL_W = $clog2(N_PROD)`.
- `CREDIT_W`, 8: credit register width, in coin units.
- `STOCK_W`, 4: per-product stock counter width.
- `PRICES`, {8'd7,8'd5,8'd3,8'd2}: packed, `N_PROD*CREDIT_W` bits. Product i's price is `PRICES[i*CREDIT_W +: CREDIT_W]`, so defaults are 2,3,5,7.
- `STOCK_INIT`, 5: stock loaded into every product at reset and on refill.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `moneda` in 2: coin code, sampled every cycle. 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- `sel_valid` in 1: selection strobe.
- `seleccion` in SEL_W: product index; valid only with `sel_valid`.
- `cancelar` in 1: refund request.
- `refill` in 1: restock all products.
- `producto` out SEL_W: index of the last vended product.
- `listo` out 1: one-cycle vend pulse.
- `cambio` out 2: change coin dispensed this cycle, same encoding as `moneda`; 00 = none.
- `credito` out CREDIT_W: current credit.
- `agotado` out 1: one-cycle pulse when a selected product has zero stock.
- `ocupado` out 1: high in VEND and CHANGE.

## Operation
- States are ACCEPT, VEND and CHANGE. Reset enters ACCEPT.
- Reset values: credit 0, all stock = STOCK_INIT, `producto`=0, `listo`=0, `cambio`=00, `agotado`=0, `ocupado`=0.

ACCEPT state:
- Each coin adds its value to credit.
- A coin whose addition would exceed 2^CREDIT_W−1 is rejected. Credit is unchanged and the same coin code appears on `cambio` the next cycle.
- Priority within a cycle: `cancelar` > `sel_valid` > `refill`. A coin present in the same cycle is always processed first.
- `cancelar`: credit_next = credit + coin. If that is nonzero, go to CHANGE; otherwise stay in ACCEPT.
- `sel_valid`:
  - Selection is checked against the credit and stock registered before this cycle's coin.
  - If stock[sel] == 0: pulse `agotado` next cycle; credit is kept.
  - Else if credit < price: ignore the selection; credit is kept.
  - Else go to VEND. Latch `producto`=sel, credit -= price (this cycle's coin is then added), stock[sel] -= 1.
- `refill` alone: set every stock counter to STOCK_INIT.

VEND state:
- `listo`=1 for exactly this cycle.
- Next state is CHANGE if credit > 0, else ACCEPT.
- Refund of remaining credit after a vend is automatic.

CHANGE state:
- Each cycle, `cambio` emits the largest coin ≤ credit (5, then 2, then 1) and subtracts its value.
- Go to ACCEPT in the cycle credit reaches 0; `cambio` returns to 00 the following cycle.

VEND and CHANGE:
- `moneda`, `sel_valid`, `cancelar` and `refill` are ignored; coins are dropped, not credited.

Reset mid-operation:
- `rst` in any state returns to ACCEPT with reset values.
- Credit is discarded; stock is reloaded.

## Timing
- All outputs are registered (Moore); none depends combinationally on inputs.
- Selection sampled at edge t: `listo`=1 and `credito` updated in cycle t+1, first change coin in t+2.
- Change latency: exactly one cycle per coin. Credit 7 produces 5, 2 (two cycles); credit 4 produces 2, 2.
- `agotado` asserts one cycle after the offending selection, for one cycle.
- Overflow rejection echo appears on `cambio` one cycle after the coin.
- Stock decrement is visible internally at t+1. Selecting the same product at t+1 is ignored because the block is `ocupado`.

## Structure
- Package `vending_pkg`:
  - coin code constants (COIN_NONE/1/2/5);
  - `coin_value()` function;
  - state enum {ACCEPT, VEND, CHANGE};
  - `largest_coin()` greedy function.
- Sub-module `change_dispenser`:
  - Inputs: load, amount (CREDIT_W).
  - Outputs: `cambio`, done.
  - Does the per-cycle greedy subtraction.
- Top of the block holds the FSM, credit register, stock array and price unpacking.

## Test plan
1. Reset, then coins 11, 10 (credit 7), select product 1 (price 3) → `listo` pulse with `producto`=1; `cambio` 10, 10 on consecutive cycles; `credito`=0; return to ACCEPT.
2. Credit 2, select product 3 (price 7) → no `listo`, credit stays 2; then `cancelar` → `cambio` 10, then 00.
3. Buy product 0 (price 2, exact credit) five times, then a sixth time → five `listo` pulses with no change; sixth gives `agotado` pulse with credit 2 kept; then `refill` and select product 0 → vend succeeds.
4. Credit 254, insert coin 01 → credit 255; insert coin 10 → rejected, `cambio`=10 next cycle, credit stays 255.
5. Coin 11 presented together with `cancelar` while credit is 1 → refund of 6 as `cambio` 11 then 01.
6. Assert `rst` during CHANGE with credit 5 remaining → next cycle all outputs at reset values, state ACCEPT, stock reloaded to 5.
